// File: rtl/rxuartlite.sv
// rxuartlite: 8N1 UART receiver with a one-byte holding register,
// sticky overrun / framing-error flags and a fixed end-to-end latency.
module rxuartlite #(
  parameter logic [9:0] CLOCKS_PER_BAUD = 10'd868,
  parameter logic [4:0] TIMING_BITS     = 5'd10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  input  logic       i_rd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned CPB = 32'(CLOCKS_PER_BAUD);
  localparam int unsigned TW  = 32'(TIMING_BITS);

  // Half a bit lands the start-bit sample mid-bit; a full bit steps mid-bit to mid-bit.
  localparam logic [TW-1:0] HALF_LOAD = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]    r_sync;
  state_t        r_state;
  logic [TW-1:0] r_count;
  logic [2:0]    r_index;
  logic [7:0]    r_shift;
  logic          r_accept;
  logic          r_ferr_evt;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_overrun;
  logic          r_frame_err;
  logic          r_busy;

  logic          w_rx;
  logic          w_count_zero;

  assign w_rx         = r_sync[1];
  assign w_count_zero = (r_count == '0);

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_uart_rx};
    end
  end

  // Receiver state machine with saturating down-counter; emits one-cycle accept / framing-error events.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_index    <= 3'd0;
      r_shift    <= 8'd0;
      r_accept   <= 1'b0;
      r_ferr_evt <= 1'b0;
    end else begin
      r_accept   <= 1'b0;
      r_ferr_evt <= 1'b0;
      if (!w_count_zero) begin
        r_count <= r_count - TW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
            r_count <= HALF_LOAD;
          end
        end
        S_START: begin
          if (w_count_zero) begin
            if (!w_rx) begin
              r_state <= S_DATA;
              r_count <= FULL_LOAD;
              r_index <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_count_zero) begin
            r_shift[r_index] <= w_rx;
            r_count          <= FULL_LOAD;
            if (r_index == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_index <= r_index + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (w_count_zero) begin
            if (w_rx) begin
              r_accept <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_ferr_evt <= 1'b1;
              r_state    <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (w_rx) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Holding register and status flags; a set event always wins over a same-cycle read clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE);

      if (r_accept) begin
        r_data <= r_shift;
      end

      if (r_accept) begin
        r_valid <= 1'b1;
      end else if (i_rd) begin
        r_valid <= 1'b0;
      end

      if (r_accept && r_valid && !i_rd) begin
        r_overrun <= 1'b1;
      end else if (i_rd && r_valid) begin
        r_overrun <= 1'b0;
      end

      if (r_ferr_evt) begin
        r_frame_err <= 1'b1;
      end else if (i_rd) begin
        r_frame_err <= 1'b0;
      end
    end
  end

endmodule
